mdu_hilo: RTL
=============

Name: mdu_hilo

Overview:
- Multiply/divide unit with HI/LO registers, sitting in the E stage beside the ALU.
- Takes the same forwarded operands the ALU operand muxes select (rs/rt values) and executes mult, multu, div, divu, mthi and mtlo.
- Its mfhi/mflo read value is carried down the pipeline into the W-stage register-data select as one of its inputs.
- Models the fixed-latency MIPS multiplier/divider and raises a stall request to the hazard unit while busy.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu.
- DIV_CYCLES, 10, busy duration in cycles for div/divu.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- MDU_op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none.
- A  input  32  forwarded rs value.
- B  input  32  forwarded rt value.
- req  input  1  exception/interrupt flush in this cycle; suppresses issue of the current E-stage op.
- busy  output  1  registered; high while a mult/div is in flight.
- stall_req  output  1  combinational; busy OR (MDU_op in 1..8 AND busy) OR (MDU_op in 1..4 AND NOT busy AND NOT req).
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.
- MDU_result  output  32  combinational; HI when op=7, LO when op=8, else 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - HI=0, LO=0, busy=0, counter=0.
  - Temp result registers cleared.
  - Any in-flight operation is discarded.
- Two states:
  - IDLE: busy=0.
  - RUN: busy=1, down-counter active.
- Issue (IDLE, op 1..4, req=0), at the rising edge:
  - Compute the 64-bit result from A and B; latch it into tmp_hi/tmp_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES; enter RUN. busy is high from the next cycle.
- mult: signed 32x32 -> 64; tmp_hi = upper 32 bits, tmp_lo = lower 32 bits.
- multu: same, unsigned.
- div/divu: tmp_lo = quotient, tmp_hi = remainder.
  - Signed division truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / -1 (signed): LO=0x80000000, HI=0.
- Divide by zero (B=0, op 3 or 4):
  - No issue: state stays IDLE, HI/LO unchanged, busy stays 0.
  - stall_req is still high in the issue cycle, as for any op 1..4.
- RUN:
  - Counter decrements each cycle.
  - In the cycle counter==1, HI<=tmp_hi, LO<=tmp_lo, and the state returns to IDLE (busy falls on the same edge).
  - busy is therefore high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
- mthi/mtlo (IDLE, req=0): HI<=A or LO<=A at the edge. No busy.
- Ops 1..8 while busy:
  - Ignored by the unit; stall_req=1.
  - The hazard unit holds the instruction in E until busy falls.
- req=1:
  - Suppresses issue of ops 1..6 in that cycle; no state change from that op.
  - Does NOT cancel an operation already in RUN (it belongs to an older, committed instruction). It completes normally.
- Issue and completion in the same cycle is impossible, because issue requires IDLE.
- mfhi/mflo read the current registered HI/LO. There is no bypass of tmp values.
- Reset deasserted mid-cycle: the first active edge after release behaves as IDLE.

Test Plan:
- Signed and unsigned multiply:
  - mult A=0xFFFFFFFF, B=0x00000002 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- Signed divide: div A=0xFFFFFFF9 (-7), B=2 -> busy high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also divu A=7, B=2 -> LO=3, HI=1.
- Divide by zero: preload HI=0x11, LO=0x22 via mthi/mtlo; then divu A=7, B=0 -> busy stays 0, HI=0x11, LO=0x22.
- Stall during busy:
  - Issue mult 3*4; one cycle later present mflo.
  - stall_req=1 for the remaining 4 busy cycles, and mflo is not acted on.
  - After busy falls, MDU_result=0x0000000C.
- Flush:
  - mult with req=1 -> no busy, HI/LO unchanged.
  - Start div 100/7; assert req during RUN -> the div still completes: LO=14, HI=2.
- Async reset: assert reset=0 three cycles into a div -> busy, HI and LO go to 0 immediately without a clock edge. After release, the next mthi A=0x5 -> HI=0x5.

Source files
------------

// File: rtl/mdu_hilo_if.sv
// rtl/mdu_hilo_if.sv - E-stage operand/result bundle between pipeline and mdu_hilo
interface mdu_hilo_if;
    logic [3:0]  MDU_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        req;
    logic        busy;
    logic        stall_req;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDU_result;

    modport master (
        output MDU_op, A, B, req,
        input  busy, stall_req, HI, LO, MDU_result
    );

    modport slave (
        input  MDU_op, A, B, req,
        output busy, stall_req, HI, LO, MDU_result
    );
endinterface

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - fixed-latency multiply/divide unit with HI/LO registers
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    mdu_hilo_if.slave mdu
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic            busy_q;
    logic [31:0]     hi_q;
    logic [31:0]     lo_q;
    logic [31:0]     tmp_hi;
    logic [31:0]     tmp_lo;

    logic [63:0]     prod_s;
    logic [63:0]     prod_u;
    logic [31:0]     a_mag;
    logic [31:0]     b_mag;
    logic [31:0]     den_s;
    logic [31:0]     den_u;
    logic [31:0]     q_mag;
    logic [31:0]     r_mag;
    logic [31:0]     quo_s;
    logic [31:0]     rem_s;
    logic [31:0]     quo_u;
    logic [31:0]     rem_u;
    logic            is_muldiv;
    logic            is_access;

    assign is_muldiv = (mdu.MDU_op >= OP_MULT) && (mdu.MDU_op <= OP_DIVU);
    assign is_access = (mdu.MDU_op >= OP_MULT) && (mdu.MDU_op <= OP_MFLO);

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no special case.
    always_comb begin
        prod_s = $signed({{32{mdu.A[31]}}, mdu.A}) * $signed({{32{mdu.B[31]}}, mdu.B});
        prod_u = {32'd0, mdu.A} * {32'd0, mdu.B};
        a_mag  = mdu.A[31] ? (~mdu.A + 32'd1) : mdu.A;
        b_mag  = mdu.B[31] ? (~mdu.B + 32'd1) : mdu.B;
        den_s  = (b_mag == 32'd0) ? 32'd1 : b_mag;
        den_u  = (mdu.B == 32'd0) ? 32'd1 : mdu.B;
        q_mag  = a_mag / den_s;
        r_mag  = a_mag % den_s;
        quo_s  = (mdu.A[31] ^ mdu.B[31]) ? (~q_mag + 32'd1) : q_mag;
        rem_s  = mdu.A[31] ? (~r_mag + 32'd1) : r_mag;
        quo_u  = mdu.A / den_u;
        rem_u  = mdu.A % den_u;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            count  <= '0;
            busy_q <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            tmp_hi <= 32'd0;
            tmp_lo <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!mdu.req) begin
                        case (mdu.MDU_op)
                            OP_MULT: begin
                                {tmp_hi, tmp_lo} <= prod_s;
                                count  <= CW'(MULT_CYCLES);
                                state  <= S_RUN;
                                busy_q <= 1'b1;
                            end
                            OP_MULTU: begin
                                {tmp_hi, tmp_lo} <= prod_u;
                                count  <= CW'(MULT_CYCLES);
                                state  <= S_RUN;
                                busy_q <= 1'b1;
                            end
                            OP_DIV: begin
                                if (mdu.B != 32'd0) begin
                                    tmp_hi <= rem_s;
                                    tmp_lo <= quo_s;
                                    count  <= CW'(DIV_CYCLES);
                                    state  <= S_RUN;
                                    busy_q <= 1'b1;
                                end
                            end
                            OP_DIVU: begin
                                if (mdu.B != 32'd0) begin
                                    tmp_hi <= rem_u;
                                    tmp_lo <= quo_u;
                                    count  <= CW'(DIV_CYCLES);
                                    state  <= S_RUN;
                                    busy_q <= 1'b1;
                                end
                            end
                            OP_MTHI: hi_q <= mdu.A;
                            OP_MTLO: lo_q <= mdu.A;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    // req is ignored here: the running op belongs to an already committed instruction.
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        hi_q   <= tmp_hi;
                        lo_q   <= tmp_lo;
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign mdu.busy       = busy_q;
    assign mdu.stall_req  = busy_q | (is_access & busy_q) | (is_muldiv & ~busy_q & ~mdu.req);
    assign mdu.HI         = hi_q;
    assign mdu.LO         = lo_q;
    assign mdu.MDU_result = (mdu.MDU_op == OP_MFHI) ? hi_q :
                            (mdu.MDU_op == OP_MFLO) ? lo_q : 32'd0;
endmodule
